// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the AES output path.
package aes_pkg;

  localparam int BLOCK_W         = 128;
  localparam int BUS_W           = 32;
  localparam int WORDS_PER_SHARE = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/aes_out_unmask.sv
// Share recombination: each 32-bit output word is the XOR of that word across all d shares.
module aes_out_unmask
  import aes_pkg::*;
#(
  parameter int d = 2
) (
  input  logic [BLOCK_W*d-1:0] shares,
  output logic [BLOCK_W-1:0]   plain
);

  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_SHARE; gi++) begin : g_word
      logic [BUS_W-1:0] word_acc;

      always_comb begin
        word_acc = '0;
        for (int s = 0; s < d; s++) begin
          word_acc = word_acc ^ shares[BLOCK_W*s + BUS_W*gi +: BUS_W];
        end
      end

      assign plain[BUS_W*gi +: BUS_W] = word_acc;
    end
  endgenerate

endmodule

// File: rtl/aes_out_serializer.sv
// Serializes a masked AES ciphertext (d shares) onto a 32-bit valid/ready stream.
// Optional macro AES_OUT_UNMASK_EN: recombine the shares and emit only 4 plain words.
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BLOCK_W*d-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_W-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
);

  localparam int CNT_W = $clog2(WORDS_PER_SHARE*d);
`ifdef AES_OUT_UNMASK_EN
  localparam int NUM_WORDS = WORDS_PER_SHARE;
`else
  localparam int NUM_WORDS = WORDS_PER_SHARE*d;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS-1);

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [BLOCK_W*d-1:0]   data_reg;
  logic                   in_ready_reg;
  logic                   capture;
  logic [BUS_W-1:0]       word_sel;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready_reg) begin
          capture    = 1'b1;
          state_next = SEND;
          cnt_next   = '0;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (cnt_reg == LAST_IDX) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // in_ready is its own flop so downstream out_ready never reaches the core combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      data_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      in_ready_reg <= (state_next == IDLE);
      if (capture) begin
        data_reg <= in_data;
      end
    end
  end

`ifdef AES_OUT_UNMASK_EN
  logic [BLOCK_W-1:0] plain;

  aes_out_unmask #(
    .d(d)
  ) u_unmask (
    .shares(data_reg),
    .plain (plain)
  );

  assign word_sel = plain[BUS_W*cnt_reg[1:0] +: BUS_W];
`else
  // Share-major layout means the flat word index walks the register in emission order.
  assign word_sel = data_reg[BUS_W*cnt_reg +: BUS_W];
`endif

  assign out_valid = (state_reg == SEND);
  assign out_data  = out_valid ? word_sel : '0;
  assign out_last  = out_valid && (cnt_reg == LAST_IDX);
  assign busy      = (state_reg == SEND);
  assign in_ready  = in_ready_reg;

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed self-checking bench for aes_out_serializer (masked build d=2, unmask build d=3).
module tb_aes_out_serializer;

`ifdef AES_OUT_UNMASK_EN
  localparam int D = 3;
`else
  localparam int D = 2;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [128*D-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_out_serializer #(.d(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #2;
    checks++;
    if ({in_ready, out_valid, out_last, busy, out_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b v=%b l=%b busy=%b d=%h want 1 0 0 0 0",
               in_ready, out_valid, out_last, busy, out_data);
    end
    step(); step();
    #2 rst = 1'b0;
    step();
    checks++;
    if ({busy, out_valid, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_no_capture got busy=%b v=%b rdy=%b want 0 0 1", busy, out_valid, in_ready);
    end
    $display("reset done");
  endtask

  task automatic test_in_ready_comb();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      out_ready = i[0];
      #3;
      checks++;
      if ({in_ready, busy} !== 2'b10) begin
        errors++;
        $display("FAIL in_ready_comb step%0d got rdy=%b busy=%b want 1 0", i, in_ready, busy);
      end
    end
    $display("in_ready stable while toggling out_ready");
    step();
  endtask

`ifndef AES_OUT_UNMASK_EN
  logic [255:0] blk_a = {128'hFFEEDDCC_BBAA9988_77665544_33221100,
                         128'h00112233_44556677_8899AABB_CCDDEEFF};
  logic [255:0] blk_b = {128'h13579BDF_2468ACE0_FEDCBA98_76543210,
                         128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0};
  logic [31:0] wa [8] = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233,
                          32'h33221100, 32'h77665544, 32'hBBAA9988, 32'hFFEEDDCC};
  logic [31:0] wb [8] = '{32'hC3D2E1F0, 32'h8796A5B4, 32'h4B5A6978, 32'h0F1E2D3C,
                          32'h76543210, 32'hFEDCBA98, 32'h2468ACE0, 32'h13579BDF};

  task automatic test_back_to_back();
    int cyc;
    out_ready = 1'b1; in_valid = 1'b1; in_data = blk_a;
    step();
    in_data = blk_b;
    cyc = 0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({out_valid, out_last, in_ready, out_data} !== {1'b1, (k == 7), 1'b0, wa[k]}) begin
        errors++;
        $display("FAIL b2b_a_word%0d got v=%b l=%b rdy=%b d=%h want 1 %b 0 %h",
                 k, out_valid, out_last, in_ready, out_data, (k == 7), wa[k]);
      end
      $display("b2b A word %0d data %h last %b", k, out_data, out_last);
      step(); cyc++;
    end
    checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL b2b_gap got rdy=%b v=%b d=%h want 1 0 0", in_ready, out_valid, out_data);
    end
    step(); cyc++;
    in_valid = 1'b0;
    checks++;
    if (cyc != 9 || out_data !== wb[0] || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_period got cycles=%0d d=%h want 9 %h", cyc, out_data, wb[0]);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({out_valid, out_last, out_data} !== {1'b1, (k == 7), wb[k]}) begin
        errors++;
        $display("FAIL b2b_b_word%0d got v=%b l=%b d=%h want 1 %b %h",
                 k, out_valid, out_last, out_data, (k == 7), wb[k]);
      end
      $display("b2b B word %0d data %h last %b", k, out_data, out_last);
      step();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1; in_valid = 1'b1; in_data = blk_a;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          checks++;
          if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, wa[3]}) begin
            errors++;
            $display("FAIL bp_stall%0d got v=%b l=%b d=%h want 1 0 %h",
                     s, out_valid, out_last, out_data, wa[3]);
          end
          step();
        end
        out_ready = 1'b1;
      end
      checks++;
      if ({out_valid, out_last, out_data} !== {1'b1, (k == 7), wa[k]}) begin
        errors++;
        $display("FAIL bp_word%0d got v=%b l=%b d=%h want 1 %b %h",
                 k, out_valid, out_last, out_data, (k == 7), wa[k]);
      end
      $display("bp word %0d data %h", k, out_data);
      step();
    end
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_end got v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_ignore_in_send();
    out_ready = 1'b0; in_valid = 1'b1; in_data = blk_a;
    step();
    in_data = blk_b;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if ({out_valid, busy, in_ready, out_data} !== {1'b1, 1'b1, 1'b0, wa[0]}) begin
        errors++;
        $display("FAIL ign_hold%0d got v=%b busy=%b rdy=%b d=%h want 1 1 0 %h",
                 s, out_valid, busy, in_ready, out_data, wa[0]);
      end
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (out_data !== wa[k]) begin
        errors++;
        $display("FAIL ign_a_word%0d got %h want %h", k, out_data, wa[k]);
      end
      $display("ign A word %0d data %h", k, out_data);
      step();
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_data} !== {1'b1, wb[0]}) begin
      errors++;
      $display("FAIL ign_b_word0 got v=%b d=%h want 1 %h", out_valid, out_data, wb[0]);
    end
    for (int k = 0; k < 8; k++) step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; in_valid = 1'b1; in_data = blk_a;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_data !== wa[k]) begin
        errors++;
        $display("FAIL rstmid_word%0d got %h want %h", k, out_data, wa[k]);
      end
      step();
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, out_last, busy, out_data} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL rstmid_async got rdy=%b v=%b l=%b busy=%b d=%h want 1 0 0 0 0",
               in_ready, out_valid, out_last, busy, out_data);
    end
    #1 rst = 1'b0;
    step();
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_idle got busy=%b v=%b want 0 0", busy, out_valid);
    end
    in_valid = 1'b1; in_data = blk_b;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({out_valid, out_last, out_data} !== {1'b1, (k == 7), wb[k]}) begin
        errors++;
        $display("FAIL rstmid_b_word%0d got v=%b l=%b d=%h want 1 %b %h",
                 k, out_valid, out_last, out_data, (k == 7), wb[k]);
      end
      $display("after reset B word %0d data %h", k, out_data);
      step();
    end
  endtask
`else
  logic [127:0] plain_t = 128'h3AD77BB4_0D7A3660_A89ECAF3_2466EF97;
  logic [127:0] sh1     = 128'h01234567_89ABCDEF_00112233_44556677;
  logic [127:0] sh2     = 128'hDEADBEEF_CAFEF00D_5A5AA5A5_0F0FF0F0;
  logic [31:0]  wu [4]  = '{32'h2466EF97, 32'hA89ECAF3, 32'h0D7A3660, 32'h3AD77BB4};

  task automatic test_unmask();
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = {sh2, sh1, plain_t ^ sh1 ^ sh2};
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({out_valid, out_last, out_data} !== {1'b1, (k == 3), wu[k]}) begin
        errors++;
        $display("FAIL unmask_word%0d got v=%b l=%b d=%h want 1 %b %h",
                 k, out_valid, out_last, out_data, (k == 3), wu[k]);
      end
      $display("unmask word %0d data %h last %b", k, out_data, out_last);
      step();
    end
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL unmask_end got v=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_in_ready_comb();
`ifndef AES_OUT_UNMASK_EN
    test_back_to_back();
    test_backpressure();
    test_ignore_in_send();
    test_reset_mid();
`else
    test_unmask();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
